// File: rtl/wb_csr_stage_if.sv
// -----------------------------------------------------------------------------
// wb_csr_stage_if
//   The MEM->WB pipeline handshake. The upstream MEM stage drives the valid
//   flag and the instruction bus. The WB stage returns wb_allowin.
//
//   mem_wb_valid  : upstream holds a valid instruction
//   wb_allowin    : WB can accept an instruction this cycle
//   mem_wb_bus    : 183-bit instruction payload. Fields from MSB to LSB:
//                   gr_we, pc, inst, final_result, dest, csr_we, csr_re,
//                   csr_num, csr_wmask, csr_wvalue, ertn
// -----------------------------------------------------------------------------
interface wb_csr_stage_if;
    logic         mem_wb_valid;
    logic         wb_allowin;
    logic [182:0] mem_wb_bus;

    modport master (output mem_wb_valid, output mem_wb_bus, input wb_allowin);
    modport slave  (input mem_wb_valid, input mem_wb_bus, output wb_allowin);
endinterface

// File: rtl/wb_csr_stage.sv
// -----------------------------------------------------------------------------
// wb_csr_stage
//   This is the write-back stage with a small CSR file. It retires one
//   instruction per cycle, writes the register file, and services CSR
//   read, write and exchange operations. It also performs ertn: the PRMD
//   fields are restored into CRMD, and a flush to ERA is requested.
//
//   clk, resetn        : rising-edge clock and async active-low reset
//   mem_wb (slave)     : MEM->WB valid/allowin handshake and instruction bus
//   rf_we/waddr/wdata  : register-file write port
//   wb_id_bus          : {wb_bypass, dest, rf_wdata}, forwarded to decode
//   ertn_flush/ertn_pc : exception-return flush request and its target
//   debug_wb_*         : retire trace
// -----------------------------------------------------------------------------
module wb_csr_stage (
    input  logic                 clk,
    input  logic                 resetn,
    wb_csr_stage_if.slave        mem_wb,
    output logic                 rf_we,
    output logic [4:0]           rf_waddr,
    output logic [31:0]          rf_wdata,
    output logic [37:0]          wb_id_bus,
    output logic                 ertn_flush,
    output logic [31:0]          ertn_pc,
    output logic [31:0]          debug_wb_pc,
    output logic [3:0]           debug_wb_rf_we,
    output logic [4:0]           debug_wb_rf_wnum,
    output logic [31:0]          debug_wb_rf_wdata
);

    localparam logic [13:0] CSR_CRMD   = 14'h000;
    localparam logic [13:0] CSR_PRMD   = 14'h001;
    localparam logic [13:0] CSR_ERA    = 14'h006;
    localparam logic [13:0] CSR_EENTRY = 14'h00C;
    localparam logic [13:0] CSR_SAVE0  = 14'h030;
    localparam logic [13:0] CSR_SAVE1  = 14'h031;
    localparam logic [13:0] CSR_SAVE2  = 14'h032;
    localparam logic [13:0] CSR_SAVE3  = 14'h033;

    typedef struct packed {
        logic        gr_we;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] final_result;
        logic [4:0]  dest;
        logic        csr_we;
        logic        csr_re;
        logic [13:0] csr_num;
        logic [31:0] csr_wmask;
        logic [31:0] csr_wvalue;
        logic        ertn;
    } wb_bus_t;

    logic    wb_valid;
    wb_bus_t bus_r;

    // CSR state. Only the implemented bits are stored.
    logic [1:0]  crmd_plv;
    logic        crmd_ie;
    logic        crmd_da;
    logic [1:0]  prmd_pplv;
    logic        prmd_pie;
    logic [31:0] csr_era;
    logic [25:0] eentry_va;
    logic [31:0] csr_save [4];

    logic [31:0] csr_rvalue;
    logic [31:0] csr_wdata;
    logic        csr_wr_en;

    // WB never stalls, so it always accepts an instruction.
    assign mem_wb.wb_allowin = 1'b1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wb_valid <= 1'b0;
        end else if (mem_wb.wb_allowin) begin
            wb_valid <= mem_wb.mem_wb_valid;
        end
    end

    // NOTE: The payload register has no reset. The valid flag guards every
    // side effect, so stale or unknown payload bits are harmless. Leaving
    // the reset off also saves a reset net on 183 flops.
    always_ff @(posedge clk) begin
        if (mem_wb.mem_wb_valid && mem_wb.wb_allowin) begin
            bus_r <= mem_wb.mem_wb_bus;
        end
    end

    // NOTE: always_comb assigns a default before the case statement. Every
    // path then drives csr_rvalue, so no latch is inferred. Unlisted CSR
    // numbers fall through to this default and read 0.
    always_comb begin
        csr_rvalue = 32'h0;
        case (bus_r.csr_num)
            CSR_CRMD:   csr_rvalue = {28'h0, crmd_da, crmd_ie, crmd_plv};
            CSR_PRMD:   csr_rvalue = {29'h0, prmd_pie, prmd_pplv};
            CSR_ERA:    csr_rvalue = csr_era;
            CSR_EENTRY: csr_rvalue = {eentry_va, 6'h0};
            CSR_SAVE0:  csr_rvalue = csr_save[0];
            CSR_SAVE1:  csr_rvalue = csr_save[1];
            CSR_SAVE2:  csr_rvalue = csr_save[2];
            CSR_SAVE3:  csr_rvalue = csr_save[3];
            default:    csr_rvalue = 32'h0;
        endcase
    end

    // The merge starts from the readable value, which already shows 0 in
    // unimplemented bits. The storage slices below then discard those bits.
    assign csr_wr_en  = wb_valid & bus_r.csr_we;
    assign csr_wdata  = (csr_rvalue & ~bus_r.csr_wmask) | (bus_r.csr_wvalue & bus_r.csr_wmask);
    assign ertn_flush = wb_valid & bus_r.ertn;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            crmd_plv  <= 2'b00;
            crmd_ie   <= 1'b0;
            crmd_da   <= 1'b1;
            prmd_pplv <= 2'b00;
            prmd_pie  <= 1'b0;
            csr_era   <= 32'h0;
            eentry_va <= 26'h0;
            for (int i = 0; i < 4; i++) csr_save[i] <= 32'h0;
        end else begin
            if (csr_wr_en) begin
                case (bus_r.csr_num)
                    CSR_CRMD: begin
                        crmd_plv <= csr_wdata[1:0];
                        crmd_ie  <= csr_wdata[2];
                        crmd_da  <= csr_wdata[3];
                    end
                    CSR_PRMD: begin
                        prmd_pplv <= csr_wdata[1:0];
                        prmd_pie  <= csr_wdata[2];
                    end
                    CSR_ERA:    csr_era     <= csr_wdata;
                    CSR_EENTRY: eentry_va   <= csr_wdata[31:6];
                    CSR_SAVE0:  csr_save[0] <= csr_wdata;
                    CSR_SAVE1:  csr_save[1] <= csr_wdata;
                    CSR_SAVE2:  csr_save[2] <= csr_wdata;
                    CSR_SAVE3:  csr_save[3] <= csr_wdata;
                    default: ;
                endcase
            end
            // NOTE: With non-blocking assignments, the last one in program
            // order wins. The ertn restore therefore overrides a same-cycle
            // CRMD write for PLV and IE. DA keeps the written value.
            if (ertn_flush) begin
                crmd_plv <= prmd_pplv;
                crmd_ie  <= prmd_pie;
            end
        end
    end

    assign rf_we    = wb_valid & bus_r.gr_we;
    assign rf_waddr = bus_r.dest;
    // A csrrd or csrxchg returns the value read before this cycle's write.
    assign rf_wdata = bus_r.csr_re ? csr_rvalue : bus_r.final_result;

    assign wb_id_bus = {wb_valid & bus_r.gr_we, bus_r.dest, rf_wdata};
    assign ertn_pc   = csr_era;

    assign debug_wb_pc       = bus_r.pc;
    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = bus_r.dest;
    assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: doc/wb_csr_stage.md
WB_CSR_STAGE -- requirements
Module: wb_csr_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk input 1, rising-edge clock; resetn input 1, asynchronous active-low reset.
REQ-002 mem_wb_valid  input  1  upstream stage holds a valid instruction.
REQ-003 wb_allowin  output  1  block can accept an instruction this cycle.
REQ-004 mem_wb_bus  input  183  fields MSB->LSB: gr_we[1], pc[32], inst[32], final_result[32], dest[5], csr_we[1], csr_re[1], csr_num[14], csr_wmask[32], csr_wvalue[32], ertn[1].
REQ-005 rf_we / rf_waddr / rf_wdata  output  1/5/32  register-file write port.
REQ-006 wb_id_bus  output  38  {wb_bypass, dest, rf_wdata} forwarded to decode.
REQ-007 ertn_flush  output  1  exception-return flush request.
REQ-008 ertn_pc  output  32  current ERA value, the flush target.
REQ-009 debug_wb_pc / debug_wb_rf_we / debug_wb_rf_wnum / debug_wb_rf_wdata  output  32/4/5/32  retire trace.

Function
REQ-010 wb_valid register: cleared on reset; when wb_allowin=1, it loads mem_wb_valid.
REQ-011 ready_go SHALL be constantly 1, so wb_allowin SHALL be constantly 1.
REQ-012 Bus register: loads mem_wb_bus when mem_wb_valid & wb_allowin; otherwise it holds. Its reset value is don't-care.
REQ-013 rf_we SHALL equal wb_valid & gr_we.
REQ-014 rf_waddr SHALL equal dest.
REQ-015 rf_wdata SHALL be csr_rvalue when csr_re=1, else final_result.
REQ-016 wb_bypass SHALL equal wb_valid & gr_we.
REQ-017 The debug outputs SHALL be: debug_wb_pc=pc, debug_wb_rf_we={4{rf_we}}, debug_wb_rf_wnum=dest, debug_wb_rf_wdata=rf_wdata.
REQ-018 The CSR file SHALL contain:
- CRMD 0x000: PLV[1:0], IE[2], DA[3]; bits 31:4 read 0.
- PRMD 0x001: PPLV[1:0], PIE[2]; bits 31:3 read 0.
- ERA 0x006: 32-bit.
- EENTRY 0x00C: bits 31:6 writable; bits 5:0 read 0.
- SAVE0-3 0x030-0x033: 32-bit each.
REQ-019 csr_rvalue SHALL be a combinational read of csr_num from current register state; any unlisted number SHALL read 0.
REQ-020 CSR write: on a clock edge with wb_valid & csr_we, the selected register SHALL update to (old & ~csr_wmask) | (csr_wvalue & csr_wmask), restricted to writable bits. Writes to unlisted numbers SHALL be ignored.
REQ-021 ertn_flush SHALL equal wb_valid & ertn.
REQ-022 On the edge ending an ertn_flush cycle, CRMD.PLV SHALL load PRMD.PPLV and CRMD.IE SHALL load PRMD.PIE.
REQ-023 Simultaneous ertn and csr_we targeting CRMD: the ertn update SHALL take precedence for PLV/IE; DA SHALL take the masked write value.
REQ-024 Simultaneous ertn and csr_we targeting any other CSR: both updates SHALL apply.
REQ-025 ertn_pc SHALL be the ERA value before any same-cycle write to ERA.
REQ-026 A read-modify-write instruction (csr_re & csr_we) SHALL return the pre-write value in rf_wdata.
REQ-027 A CSR written by instruction N SHALL be visible to instruction N+1 in the next WB cycle.
REQ-028 With wb_valid=0, no CSR or register-file side effects SHALL occur, regardless of stale bus contents.

Reset
REQ-029 Asserting resetn low SHALL immediately clear wb_valid, rf_we, ertn_flush and the debug_wb_rf_we bits, including in the middle of a transfer.
REQ-030 CSR reset values: CRMD=0x00000008 (PLV=0, IE=0, DA=1), PRMD=0, ERA=0, EENTRY=0, SAVE0-3=0.
REQ-031 After reset deassertion, the first accepted instruction SHALL appear in WB one cycle after its handshake.

Verification
REQ-032 Reset: assert resetn=0 mid-stream -> rf_we=0 and ertn_flush=0 at once; a read of CRMD returns 0x00000008.
REQ-033 Masked write: csr_we to SAVE1 with wvalue=0xFFFF0000, mask=0x0F0F0F0F over old value 0x12345678 -> SAVE1=0x1F3F5070.
REQ-034 csrxchg: csr_re=csr_we=1 on ERA (old 0x1C000100), wvalue=0x1C000200, full mask -> rf_wdata=0x1C000100; next-cycle read of ERA = 0x1C000200.
REQ-035 ertn: PRMD=0x7, then ertn -> ertn_flush=1 for one cycle, ertn_pc=ERA; CRMD next cycle = 0x0000000F.
REQ-036 Unlisted CSR: write 0xDEADBEEF to csr_num 0x3FF -> no register changes; a read of 0x3FF returns 0.
REQ-037 Bubble: mem_wb_valid=0 with csr_we=1 and gr_we=1 on the bus -> rf_we=0 and all CSRs unchanged.
